// File: rtl/sg_conformance_monitor_if.sv
// Signal bundle between the observed circuit, the config port and the monitor.
// Carries the optional cov vector when SG_CONFORMANCE_MONITOR_COVER_EN is set.
interface sg_conformance_monitor_if #(
    parameter int N_SIG      = 8,
    parameter int STATE_BITS = 6,
    parameter int N_TRANS    = 32,
    parameter int CNT_BITS   = 16
);
    localparam int SIG_W = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam int IDX_W = (N_TRANS > 1) ? $clog2(N_TRANS) : 1;
    localparam int CFG_W = 2 * STATE_BITS + SIG_W + 2;

    logic [N_SIG-1:0]      sig;
    logic                  ena;
    logic                  halt_on_err;
    logic                  clr_err;
    logic                  cfg_we;
    logic [IDX_W-1:0]      cfg_idx;
    logic [CFG_W-1:0]      cfg_data;
    logic [STATE_BITS-1:0] state;
    logic                  err;
    logic [1:0]            err_code;
    logic [STATE_BITS-1:0] err_state;
    logic [SIG_W-1:0]      err_sig;
    logic                  err_dir;
    logic [CNT_BITS-1:0]   viol_cnt;
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
    logic [N_TRANS-1:0]    cov;
`endif

    modport master (
        output sig, ena, halt_on_err, clr_err,
        output cfg_we, cfg_idx, cfg_data,
        input  state, err, err_code, err_state,
        input  err_sig, err_dir, viol_cnt
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
        , input cov
`endif
    );

    modport slave (
        input  sig, ena, halt_on_err, clr_err,
        input  cfg_we, cfg_idx, cfg_data,
        output state, err, err_code, err_state,
        output err_sig, err_dir, viol_cnt
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
        , output cov
`endif
    );
endinterface

// File: rtl/sg_conformance_monitor.sv
// Run-time programmable state-graph checker for a group of handshake signals.
// Define SG_CONFORMANCE_MONITOR_COVER_EN to add sticky per-entry coverage (cov).
module sg_conformance_monitor #(
    parameter int                    N_SIG      = 8,
    parameter int                    STATE_BITS = 6,
    parameter int                    N_TRANS    = 32,
    parameter logic [STATE_BITS-1:0] INIT_STATE = '0,
    parameter logic [N_SIG-1:0]      SIG_INIT   = '0,
    parameter int                    CNT_BITS   = 16
) (
    input logic                   clk,
    input logic                   reset,
    sg_conformance_monitor_if.slave bus
);
    localparam int SIG_W = (N_SIG > 1) ? $clog2(N_SIG) : 1;
    localparam int IDX_W = (N_TRANS > 1) ? $clog2(N_TRANS) : 1;

    logic                  tv_q [N_TRANS];
    logic [STATE_BITS-1:0] tf_q [N_TRANS];
    logic [SIG_W-1:0]      ts_q [N_TRANS];
    logic                  td_q [N_TRANS];
    logic [STATE_BITS-1:0] tt_q [N_TRANS];

    logic [N_SIG-1:0]      sig_q;
    logic [STATE_BITS-1:0] state_q, state_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic [STATE_BITS-1:0] estate_q, estate_d;
    logic [SIG_W-1:0]      esig_q, esig_d;
    logic                  edir_q, edir_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic                  cf_v, cf_dir;
    logic [STATE_BITS-1:0] cf_from, cf_to;
    logic [SIG_W-1:0]      cf_sidx;

    assign {cf_v, cf_from, cf_sidx, cf_dir, cf_to} = bus.cfg_data;

    logic [N_SIG-1:0]      edges;
    logic                  multi, got, many, edir;
    logic [SIG_W-1:0]      eidx;
    logic [STATE_BITS-1:0] tgt;
    logic                  eval, viol, legal, halted;
    logic [1:0]            vcode;
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
    logic [IDX_W-1:0]      hidx;
    logic [N_TRANS-1:0]    cov_q, cov_d;
`endif

    assign edges = bus.sig ^ sig_q;
    assign multi = |(edges & (edges - N_SIG'(1)));

    // Descending scan leaves the lowest-index edge in eidx.
    always_comb begin
        eidx = '0;
        for (int i = N_SIG - 1; i >= 0; i--) begin
            if (edges[i]) eidx = SIG_W'(i);
        end
        edir = bus.sig[eidx];
    end

    always_comb begin
        got  = 1'b0;
        many = 1'b0;
        tgt  = state_q;
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
        hidx = '0;
`endif
        for (int i = 0; i < N_TRANS; i++) begin
            if (tv_q[i] && tf_q[i] == state_q &&
                ts_q[i] == eidx && td_q[i] == edir) begin
                many = many | got;
                got  = 1'b1;
                tgt  = tt_q[i];
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
                hidx = IDX_W'(i);
`endif
            end
        end
    end

    assign eval   = bus.ena && (|edges);
    assign viol   = eval && (multi || !got || many);
    assign legal  = eval && !viol;
    assign halted = err_q && bus.halt_on_err;
    assign vcode  = multi ? 2'd2 : (many ? 2'd3 : 2'd1);

    // Clear is applied first so a same-cycle violation recaptures on top.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        code_d   = code_q;
        estate_d = estate_q;
        esig_d   = esig_q;
        edir_d   = edir_q;
        cnt_d    = cnt_q;
        if (bus.clr_err) begin
            err_d    = 1'b0;
            code_d   = 2'd0;
            estate_d = '0;
            esig_d   = '0;
            edir_d   = 1'b0;
            cnt_d    = '0;
        end
        if (viol) begin
            if (cnt_d != '1) cnt_d = cnt_d + CNT_BITS'(1);
            if (!err_d) begin
                err_d    = 1'b1;
                code_d   = vcode;
                estate_d = state_q;
                esig_d   = eidx;
                edir_d   = edir;
            end
        end else if (legal && !halted) begin
            state_d = tgt;
        end
    end

`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
    always_comb begin
        cov_d = bus.clr_err ? '0 : cov_q;
        if (legal && !halted) cov_d[hidx] = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q    <= SIG_INIT;
            state_q  <= INIT_STATE;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            estate_q <= '0;
            esig_q   <= '0;
            edir_q   <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < N_TRANS; i++) begin
                tv_q[i] <= 1'b0;
                tf_q[i] <= '0;
                ts_q[i] <= '0;
                td_q[i] <= 1'b0;
                tt_q[i] <= '0;
            end
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
            cov_q    <= '0;
`endif
        end else begin
            sig_q    <= bus.sig;
            state_q  <= state_d;
            err_q    <= err_d;
            code_q   <= code_d;
            estate_q <= estate_d;
            esig_q   <= esig_d;
            edir_q   <= edir_d;
            cnt_q    <= cnt_d;
            if (bus.cfg_we) begin
                tv_q[bus.cfg_idx] <= cf_v;
                tf_q[bus.cfg_idx] <= cf_from;
                ts_q[bus.cfg_idx] <= cf_sidx;
                td_q[bus.cfg_idx] <= cf_dir;
                tt_q[bus.cfg_idx] <= cf_to;
            end
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
            cov_q    <= cov_d;
`endif
        end
    end

    assign bus.state     = state_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;
    assign bus.err_state = estate_q;
    assign bus.err_sig   = esig_q;
    assign bus.err_dir   = edir_q;
    assign bus.viol_cnt  = cnt_q;
`ifdef SG_CONFORMANCE_MONITOR_COVER_EN
    assign bus.cov       = cov_q;
`endif
endmodule
